// File: rtl/jt49_env_multi.sv
// Multi-channel AY/YM style envelope generator: one prescaler, level counter
// and shape state per channel, all advancing on the shared clock enable.
module jt49_env_multi #(
  parameter int W   = 5,
  parameter int PW  = 16,
  parameter int NCH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [NCH*PW-1:0] period,
  input  logic [NCH*4-1:0]  ctrl,
  input  logic [NCH-1:0]    restart,
  output logic [NCH*W-1:0]  env,
  output logic [NCH-1:0]    holding
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [PW-1:0] w_period;
    logic [PW-1:0] w_eff_m1;
    logic          w_cont;
    logic          w_att;
    logic          w_alt;
    logic          w_hold;
    logic          w_step;
    logic          w_toggle;

    logic [PW-1:0] r_cnt;
    logic [W-1:0]  r_gain;
    logic [W-1:0]  r_env;
    logic          r_inv;
    logic          r_stop;
    logic          r_pend;

    assign w_period = period[i*PW +: PW];
    // A zero period behaves like a period of one.
    assign w_eff_m1 = (w_period == '0) ? '0 : w_period - PW'(1);
    assign w_step   = (r_cnt >= w_eff_m1);
    assign w_cont   = ctrl[i*4 + 3];
    assign w_att    = ctrl[i*4 + 2];
    assign w_alt    = ctrl[i*4 + 1];
    assign w_hold   = ctrl[i*4 + 0];
    assign w_toggle = (!w_cont && w_att) || (w_cont && w_alt);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_gain <= '1;
        r_env  <= '0;
        r_inv  <= 1'b0;
        r_stop <= 1'b0;
        r_pend <= 1'b0;
      end else begin
        // A restart arriving on the servicing edge stays pending for the next one.
        if (cen) r_pend <= restart[i];
        else     r_pend <= r_pend | restart[i];

        if (cen) begin
          r_env <= r_inv ? ~r_gain : r_gain;
          if (r_pend) begin
            r_gain <= '1;
            r_inv  <= w_att;
            r_stop <= 1'b0;
            r_cnt  <= '0;
          end else begin
            r_cnt <= w_step ? '0 : r_cnt + PW'(1);
            if (w_step && !r_stop) begin
              if (r_gain != '0) begin
                r_gain <= r_gain - W'(1);
              end else begin
                if (!w_cont || w_hold) r_stop <= 1'b1;
                else                   r_gain <= '1;
                if (w_toggle) r_inv <= ~r_inv;
              end
            end
          end
        end
      end
    end

    assign env[i*W +: W] = r_env;
    assign holding[i]    = r_stop;
  end

endmodule
